// File: rtl/si571_pll_pkg.sv
// Shared types and defaults for the Si571 PLL loop filter: FSM state
// encoding, default parameter values and loss-counter helpers.
package si571_pll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } pll_state_e;

  localparam int DEF_DW       = 16;
  localparam int DEF_ACC_W    = 24;
  localparam int DEF_DECIM    = 1024;
  localparam int DEF_LOCK_CNT = 1250000;
  localparam int LOSS_CNT_W   = 16;

  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE = {{(LOSS_CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [LOSS_CNT_W-1:0] loss_sat_inc(input logic [LOSS_CNT_W-1:0] v);
    if (v == {LOSS_CNT_W{1'b1}}) begin
      loss_sat_inc = v;
    end else begin
      loss_sat_inc = v + LOSS_ONE;
    end
  endfunction

endpackage

// File: rtl/si571_pll_sync.sv
// Two-flop synchroniser for one asynchronous detector line into clk_i.
module si571_pll_sync
  import si571_pll_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic pll_ff_rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter chain
  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/si571_pll_loop_filter.sv
// Si571 PLL loop filter: saturating pump integrator, decimated offset-binary
// VCXO word and lock supervision. Define SI571_PLL_HOLDOVER_EN to freeze the
// integrator while the loop is in LOST.
module si571_pll_loop_filter
  import si571_pll_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int DECIM    = DEF_DECIM,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic                  clk_i,
  input  logic                  pll_ff_rst,
  input  logic                  pll_cfg_en,
  input  logic                  pll_hi_i,
  input  logic                  pll_lo_i,
  input  logic                  pll_ok_i,
  input  logic                  loss_clr_i,
  output logic [DW-1:0]         ctrl_word_o,
  output logic                  ctrl_valid_o,
  output logic                  lock_o,
  output logic [1:0]            state_o,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int QW  = $clog2(LOCK_CNT + 1);

  localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_ONE   = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]    CTRL_MID  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DCW-1:0]   DEC_LAST  = DCW'(DECIM - 1);
  localparam logic [DCW-1:0]   DEC_ONE   = {{(DCW-1){1'b0}}, 1'b1};
  localparam logic [QW-1:0]    QUAL_LAST = QW'(LOCK_CNT - 1);
  localparam logic [QW-1:0]    QUAL_ONE  = {{(QW-1){1'b0}}, 1'b1};

  logic             hi_s, lo_s, ok_s;
  pll_state_e       state_r;
  logic [QW-1:0]    qual_r;
  logic [ACC_W-1:0] acc_r, acc_nxt_s;
  logic [DCW-1:0]   dec_r;
  logic             dec_wrap_s, int_en_s, loss_ev_s;

  si571_pll_sync u_sync_hi (.clk_i(clk_i), .pll_ff_rst(pll_ff_rst), .d(pll_hi_i), .q(hi_s));
  si571_pll_sync u_sync_lo (.clk_i(clk_i), .pll_ff_rst(pll_ff_rst), .d(pll_lo_i), .q(lo_s));
  si571_pll_sync u_sync_ok (.clk_i(clk_i), .pll_ff_rst(pll_ff_rst), .d(pll_ok_i), .q(ok_s));

`ifdef SI571_PLL_HOLDOVER_EN
  assign int_en_s = (state_r == ST_ACQUIRE) || (state_r == ST_LOCKED);
`else
  assign int_en_s = (state_r == ST_ACQUIRE) || (state_r == ST_LOCKED) || (state_r == ST_LOST);
`endif

  assign dec_wrap_s = (dec_r == DEC_LAST);
  assign loss_ev_s  = pll_cfg_en && (state_r == ST_LOCKED) && !ok_s;

  // Next integrator value: clear when disabled, else saturating +/-1 step
  always_comb begin
    acc_nxt_s = acc_r;
    if (!pll_cfg_en || (state_r == ST_IDLE)) begin
      acc_nxt_s = '0;
    end else if (int_en_s && hi_s && lo_s && (acc_r != ACC_MAX)) begin
      acc_nxt_s = acc_r + ACC_ONE;
    end else if (int_en_s && !hi_s && !lo_s && (acc_r != ACC_MIN)) begin
      acc_nxt_s = acc_r - ACC_ONE;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Integrator, free-running decimator and offset-binary output word
  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      acc_r        <= '0;
      dec_r        <= '0;
      ctrl_word_o  <= CTRL_MID;
      ctrl_valid_o <= 1'b0;
    end else begin
      acc_r        <= acc_nxt_s;
      dec_r        <= dec_wrap_s ? '0 : (dec_r + DEC_ONE);
      ctrl_valid_o <= dec_wrap_s;
      if (dec_wrap_s) begin
        ctrl_word_o <= acc_r[ACC_W-1 -: DW] ^ CTRL_MID;
      end
    end
  end

  // Lock supervision FSM; status outputs are a registered view of the state
  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      state_r <= ST_IDLE;
      qual_r  <= '0;
      state_o <= 2'd0;
      lock_o  <= 1'b0;
    end else begin
      state_o <= state_r;
      lock_o  <= (state_r == ST_LOCKED);
      if (!pll_cfg_en) begin
        state_r <= ST_IDLE;
        qual_r  <= '0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_ACQUIRE;
            qual_r  <= '0;
          end
          ST_ACQUIRE, ST_LOST: begin
            if (!ok_s) begin
              qual_r <= '0;
            end else if (qual_r == QUAL_LAST) begin
              qual_r  <= '0;
              state_r <= ST_LOCKED;
            end else begin
              qual_r <= qual_r + QUAL_ONE;
            end
          end
          ST_LOCKED: begin
            qual_r <= '0;
            if (!ok_s) begin
              state_r <= ST_LOST;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            qual_r  <= '0;
          end
        endcase
      end
    end
  end

  // Loss-event counter; a clear landing on a loss event leaves a count of one
  always_ff @(posedge clk_i or negedge pll_ff_rst) begin
    if (!pll_ff_rst) begin
      loss_cnt_o <= '0;
    end else if (loss_ev_s) begin
      loss_cnt_o <= loss_clr_i ? LOSS_ONE : loss_sat_inc(loss_cnt_o);
    end else if (loss_clr_i) begin
      loss_cnt_o <= '0;
    end else begin
      loss_cnt_o <= loss_cnt_o;
    end
  end

endmodule

// File: tb/tb_si571_pll_loop_filter.sv
// Scoreboard bench for si571_pll_loop_filter (DW=4, ACC_W=8, DECIM=4, LOCK_CNT=16).
`timescale 1ns/1ps
module tb_si571_pll_loop_filter;

  localparam int DW = 4, ACC_W = 8, DECIM = 4, LOCK_CNT = 16;

  logic          clk_i = 1'b0;
  logic          pll_ff_rst = 1'b0;
  logic          pll_cfg_en = 1'b0;
  logic          pll_hi_i = 1'b1;
  logic          pll_lo_i = 1'b0;
  logic          pll_ok_i = 1'b0;
  logic          loss_clr_i = 1'b0;
  logic [DW-1:0] ctrl_word_o;
  logic          ctrl_valid_o;
  logic          lock_o;
  logic [1:0]    state_o;
  logic [15:0]   loss_cnt_o;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            strobe_cnt = 0;
  logic [DW-1:0] exp_q[$];
  string         name_q[$];
  logic [DW-1:0] mon_w;
  string         mon_nm;

  always #5 clk_i = ~clk_i;

  si571_pll_loop_filter #(.DW(DW), .ACC_W(ACC_W), .DECIM(DECIM), .LOCK_CNT(LOCK_CNT)) dut (
    .clk_i(clk_i), .pll_ff_rst(pll_ff_rst), .pll_cfg_en(pll_cfg_en),
    .pll_hi_i(pll_hi_i), .pll_lo_i(pll_lo_i), .pll_ok_i(pll_ok_i),
    .loss_clr_i(loss_clr_i), .ctrl_word_o(ctrl_word_o), .ctrl_valid_o(ctrl_valid_o),
    .lock_o(lock_o), .state_o(state_o), .loss_cnt_o(loss_cnt_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Drive a pump pattern for n full cycles, then return to the hold pattern
  task automatic pump(input logic h, input logic l, input int n);
    pll_hi_i = h;
    pll_lo_i = l;
    cyc(n);
    pll_hi_i = 1'b1;
    pll_lo_i = 1'b0;
  endtask

  // Let the integrator settle, queue the expected word, give the monitor time to see a strobe
  task automatic expect_word(input string nm, input logic [DW-1:0] w);
    cyc(4);
    exp_q.push_back(w);
    name_q.push_back(nm);
    cyc(3 * DECIM);
  endtask

  // Monitor: every strobe counts; a pending expectation is popped and compared
  always @(negedge clk_i) begin
    if (pll_ff_rst && ctrl_valid_o) begin
      strobe_cnt++;
      if (exp_q.size() > 0) begin
        mon_w  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        chk(mon_nm, {28'd0, ctrl_word_o}, {28'd0, mon_w});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int s0;
    cyc(3);
    chk("rst_word",  {28'd0, ctrl_word_o}, 32'h8);
    chk("rst_valid", {31'd0, ctrl_valid_o}, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_lock",  {31'd0, lock_o}, 32'd0);
    chk("rst_loss",  {16'd0, loss_cnt_o}, 32'd0);
    pll_ff_rst = 1'b1;

    @(posedge clk_i);
    s0 = strobe_cnt;
    repeat (16) @(posedge clk_i);
    chk("idle_strobe_rate", strobe_cnt - s0, 32'd4);
    @(negedge clk_i);
    expect_word("idle_word", 4'h8);

    pll_cfg_en = 1'b1;
    cyc(4);
    chk("acq_state", {30'd0, state_o}, 32'd1);
    pump(1'b1, 1'b1, 40);   expect_word("up40", 4'hA);
    pump(1'b0, 1'b0, 40);   expect_word("down40", 4'h8);
    pump(1'b0, 1'b0, 20);   expect_word("neg20", 4'h6);
    pump(1'b1, 1'b1, 20);   expect_word("zero", 4'h8);
    pump(1'b1, 1'b1, 300);  expect_word("sat_hi", 4'hF);
    pump(1'b0, 1'b0, 1);    expect_word("sat_hi_m1", 4'hF);
    pump(1'b0, 1'b0, 15);   expect_word("sat_hi_m16", 4'hE);
    pump(1'b0, 1'b0, 300);  expect_word("sat_lo", 4'h0);
    pump(1'b1, 1'b1, 1);    expect_word("sat_lo_p1", 4'h0);
    pump(1'b1, 1'b1, 127);  expect_word("back_zero", 4'h8);

    // Lock qualification: a 15-run broken by one low cycle, then a full 16-run
    pll_ok_i = 1'b1; cyc(15);
    pll_ok_i = 1'b0; cyc(1);
    pll_ok_i = 1'b1; cyc(18);
    chk("lock_early", {31'd0, lock_o}, 32'd0);
    chk("acq_hold_state", {30'd0, state_o}, 32'd1);
    cyc(1);
    chk("lock_on", {31'd0, lock_o}, 32'd1);
    chk("locked_state", {30'd0, state_o}, 32'd2);

    pll_ok_i = 1'b0; cyc(6);
    chk("lost_state", {30'd0, state_o}, 32'd3);
    chk("lost_lock", {31'd0, lock_o}, 32'd0);
    chk("loss_one", {16'd0, loss_cnt_o}, 32'd1);
    pll_ok_i = 1'b1; cyc(24);
    chk("relock_state", {30'd0, state_o}, 32'd2);
    chk("relock_loss", {16'd0, loss_cnt_o}, 32'd1);

    // Second loss lands on the same edge as a clear
    pll_ok_i = 1'b0; cyc(2);
    loss_clr_i = 1'b1; cyc(1);
    loss_clr_i = 1'b0; cyc(3);
    chk("clr_with_loss", {16'd0, loss_cnt_o}, 32'd1);
    chk("lost2_state", {30'd0, state_o}, 32'd3);

    pump(1'b1, 1'b1, 64);
`ifdef SI571_PLL_HOLDOVER_EN
    expect_word("holdover", 4'h8);
`else
    expect_word("lost_run", 4'hC);
`endif
    chk("lost_stay", {30'd0, state_o}, 32'd3);

    pll_cfg_en = 1'b0; cyc(3);
    chk("idle_state", {30'd0, state_o}, 32'd0);
    chk("idle_lock", {31'd0, lock_o}, 32'd0);
    expect_word("idle_clear", 4'h8);
    chk("idle_loss_kept", {16'd0, loss_cnt_o}, 32'd1);
    loss_clr_i = 1'b1; cyc(1);
    loss_clr_i = 1'b0; cyc(1);
    chk("loss_clear", {16'd0, loss_cnt_o}, 32'd0);

    pll_cfg_en = 1'b1; cyc(3);
    pump(1'b1, 1'b1, 32);   expect_word("pre_reset", 4'hA);
    #2 pll_ff_rst = 1'b0;
    #1;
    chk("midrst_word", {28'd0, ctrl_word_o}, 32'h8);
    chk("midrst_state", {30'd0, state_o}, 32'd0);
    chk("midrst_valid", {31'd0, ctrl_valid_o}, 32'd0);
    cyc(2);
    pll_ff_rst = 1'b1;
    cyc(2);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
